// File: rtl/key_toggle_debouncer_if.sv
// Key pin / debounced-output bundle for key_toggle_debouncer.
// slave = debouncer side, master = pin driver and consumer of the outputs.
interface key_toggle_debouncer_if #(
    parameter int NUM_KEYS = 2
);
    logic [NUM_KEYS-1:0] key;
    logic [NUM_KEYS-1:0] keyLevel;
    logic [NUM_KEYS-1:0] keyPulse;
    logic [NUM_KEYS-1:0] modeSelect;

    modport master (output key, input keyLevel, input keyPulse, input modeSelect);
    modport slave  (input key, output keyLevel, output keyPulse, output modeSelect);
endinterface

// File: rtl/key_toggle_debouncer.sv
// Per-key synchroniser, counter debouncer, press pulse and toggle bit, all on clk.
// Optional auto-repeat of keyPulse while held: define KEY_AUTOREPEAT_EN.
module key_toggle_lane #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACTIVE_LOW      = 1
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic level_o,
    output logic pulse_o,
    output logic mode_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic         pin;
    logic         sync1_q, sync1_d;
    logic         sync2_q, sync2_d;
    state_t       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         level_q, level_d;
    logic         pulse_q, pulse_d;
    logic         mode_q, mode_d;

`ifdef KEY_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RCW     = $clog2(RPT_MAX + 1);
    localparam logic [RCW-1:0] DELAY_LIM = RCW'(REPEAT_DELAY);
    localparam logic [RCW-1:0] RATE_LIM  = RCW'(REPEAT_RATE);

    // rpt_first_q selects the initial delay; it is re-armed on every entry to PRESSED.
    logic [RCW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic           rpt_first_q, rpt_first_d;
    logic [RCW-1:0] rpt_next, rpt_limit;
`endif

    // Normalise so 1 always means pressed; reset loads 0 so reset never looks like a press.
    assign pin = (ACTIVE_LOW != 0) ? ~key_raw : key_raw;

    always_comb begin
        sync1_d = pin;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
        mode_d  = mode_q;
`ifdef KEY_AUTOREPEAT_EN
        rpt_cnt_d   = rpt_cnt_q;
        rpt_first_d = rpt_first_q;
        rpt_next    = rpt_cnt_q + RCW'(1);
        rpt_limit   = rpt_first_q ? DELAY_LIM : RATE_LIM;
`endif
        case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
                    mode_d  = ~mode_q;
`ifdef KEY_AUTOREPEAT_EN
                    rpt_cnt_d   = '0;
                    rpt_first_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESSED: begin
                if (!sync2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CW'(1);
`ifdef KEY_AUTOREPEAT_EN
                    rpt_cnt_d   = '0;
                    rpt_first_d = 1'b1;
                end else if (rpt_next == rpt_limit) begin
                    // Repeat pulses never touch mode_d.
                    pulse_d     = 1'b1;
                    rpt_cnt_d   = '0;
                    rpt_first_d = 1'b0;
                end else begin
                    rpt_cnt_d = rpt_next;
`endif
                end
            end
            RELEASE_WAIT: begin
                if (sync2_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
`ifdef KEY_AUTOREPEAT_EN
                    rpt_cnt_d   = '0;
                    rpt_first_d = 1'b1;
`endif
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            mode_q  <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
`endif
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            mode_q  <= mode_d;
`ifdef KEY_AUTOREPEAT_EN
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
`endif
        end
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;
    assign mode_o  = mode_q;
endmodule

module key_toggle_debouncer #(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic                  clk,
    input  logic                  reset,
    key_toggle_debouncer_if.slave bus
);
    logic [NUM_KEYS-1:0] level_w;
    logic [NUM_KEYS-1:0] pulse_w;
    logic [NUM_KEYS-1:0] mode_w;

    if (NUM_KEYS < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_err
        $error("key_toggle_debouncer: NUM_KEYS, DEBOUNCE_CYCLES and REPEAT_* must be >= 1");
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
        key_toggle_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
`ifdef KEY_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
`endif
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .key_raw(bus.key[i]),
            .level_o(level_w[i]),
            .pulse_o(pulse_w[i]),
            .mode_o (mode_w[i])
        );
    end

    assign bus.keyLevel   = level_w;
    assign bus.keyPulse   = pulse_w;
    assign bus.modeSelect = mode_w;
endmodule

// File: tb/tb_key_toggle_debouncer.sv
// Bench for key_toggle_debouncer: run-length reference model feeds a scoreboard queue,
// a monitor compares every cycle; directed scenarios then randomized bouncing keys.
module tb_key_toggle_debouncer;
    localparam int NK = 2;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    typedef struct packed {
        logic [NK-1:0] lvl;
        logic [NK-1:0] pls;
        logic [NK-1:0] mode;
    } exp_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   pcnt[NK];
    int   lastp[NK];
    exp_t exp_q[$];

    key_toggle_debouncer_if #(.NUM_KEYS(NK)) bus ();

    key_toggle_debouncer #(
        .NUM_KEYS       (NK),
        .DEBOUNCE_CYCLES(D),
        .ACTIVE_LOW     (1),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: pin delayed two edges, then a level flips once D+1 consecutive
    // samples disagree with it; any agreeing sample restarts the run.
    logic [NK-1:0] m_h1 = '0, m_h2 = '0, m_lvl = '0, m_pls = '0, m_mode = '0;
    int            m_run[NK];
`ifdef KEY_AUTOREPEAT_EN
    int            m_since[NK];
    bit            m_first[NK];
`endif

    task automatic model_step(input logic [NK-1:0] k, input logic r);
        logic [NK-1:0] s;
        if (r) begin
            m_h1 = '0; m_h2 = '0; m_lvl = '0; m_pls = '0; m_mode = '0;
            for (int i = 0; i < NK; i++) m_run[i] = 0;
        end else begin
            s     = m_h2;
            m_h2  = m_h1;
            m_h1  = ~k;
            m_pls = '0;
            for (int i = 0; i < NK; i++) begin
                if (s[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D + 1) begin
                        m_lvl[i] = s[i];
                        m_run[i] = 0;
                        if (s[i]) begin
                            m_pls[i]  = 1'b1;
                            m_mode[i] = ~m_mode[i];
`ifdef KEY_AUTOREPEAT_EN
                            m_since[i] = 0;
                            m_first[i] = 1'b1;
`endif
                        end
                    end
                end else begin
`ifdef KEY_AUTOREPEAT_EN
                    if (m_lvl[i]) begin
                        if (m_run[i] != 0) begin
                            m_since[i] = 0;
                            m_first[i] = 1'b1;
                        end else begin
                            m_since[i]++;
                            if (m_since[i] == (m_first[i] ? RD : RR)) begin
                                m_pls[i]   = 1'b1;
                                m_since[i] = 0;
                                m_first[i] = 1'b0;
                            end
                        end
                    end
`endif
                    m_run[i] = 0;
                end
            end
        end
    endtask

    task automatic step(input logic [NK-1:0] k, input logic r);
        @(negedge clk);
        bus.key = k;
        reset   = r;
        @(posedge clk);
        cyc++;
        model_step(k, r);
        exp_q.push_back('{lvl: m_lvl, pls: m_pls, mode: m_mode});
    endtask

    task automatic steps(input logic [NK-1:0] k, input int n);
        for (int i = 0; i < n; i++) step(k, 1'b0);
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Monitor: one popped expectation per clock edge that the driver produced.
    initial begin
        exp_t e;
        for (int i = 0; i < NK; i++) begin pcnt[i] = 0; lastp[i] = -1; end
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({bus.keyLevel, bus.keyPulse, bus.modeSelect} !== {e.lvl, e.pls, e.mode}) begin
                    errors++;
                    $display("FAIL scoreboard cyc %0d: got lvl=%b pls=%b mode=%b want lvl=%b pls=%b mode=%b",
                             cyc, bus.keyLevel, bus.keyPulse, bus.modeSelect, e.lvl, e.pls, e.mode);
                end
                for (int i = 0; i < NK; i++)
                    if (bus.keyPulse[i] === 1'b1) begin pcnt[i]++; lastp[i] = cyc; end
            end
        end
    end

    initial begin
        int p0, p1, t0;
        logic [NK-1:0] cur;
        logic [NK-1:0] m0;
        int hold[NK];
        bus.key = '1;
        reset   = 1'b1;

        // Reset with keys released, then quiet.
        for (int i = 0; i < 3; i++) step(2'b11, 1'b1);
        #2;
        chk("reset keyLevel", int'(bus.keyLevel), 0);
        chk("reset keyPulse", int'(bus.keyPulse), 0);
        chk("reset modeSelect", int'(bus.modeSelect), 0);
        steps(2'b11, 20);
        #2 chk("no pulse after reset", pcnt[0] + pcnt[1], 0);

        // Clean press of key 0.
        p0 = pcnt[0];
        t0 = cyc + 1;
        steps(2'b10, 20);
        #2;
        chk("clean press pulses", pcnt[0] - p0, 1);
        chk("clean press latency", lastp[0] - t0, 2 + D);
        chk("clean press level", int'(bus.keyLevel), 1);
        chk("clean press mode", int'(bus.modeSelect), 1);
        steps(2'b11, 10);

        // Bounce is rejected, then a real press flips mode[0] back.
        p0 = pcnt[0];
        steps(2'b10, 3); steps(2'b11, 1); steps(2'b10, 3); steps(2'b11, 10);
        #2;
        chk("bounce pulses", pcnt[0] - p0, 0);
        chk("bounce mode", int'(bus.modeSelect), 1);
        steps(2'b10, 10); steps(2'b11, 10);
        #2 chk("press after bounce mode", int'(bus.modeSelect), 0);

        // Both keys together, then key 1 toggles back.
        p0 = pcnt[0]; p1 = pcnt[1];
        steps(2'b00, 12);
        #2;
        chk("two-key pulses", (pcnt[0] - p0) + (pcnt[1] - p1), 2);
        chk("two-key same cycle", lastp[1] - lastp[0], 0);
        chk("two-key mode", int'(bus.modeSelect), 3);
        steps(2'b11, 10);
        steps(2'b01, 12);
        #2 chk("key1 toggle back mode", int'(bus.modeSelect), 1);
        steps(2'b11, 10);

        // Release glitch while pressed, then reset mid-press.
        steps(2'b10, 12);
        p0 = pcnt[0];
        steps(2'b11, 2); steps(2'b10, 10);
        #2;
        chk("release glitch level", int'(bus.keyLevel), 1);
        chk("release glitch pulses", pcnt[0] - p0, 0);
        step(2'b10, 1'b1);
        #2;
        chk("mid-press reset level", int'(bus.keyLevel), 0);
        chk("mid-press reset pulse", int'(bus.keyPulse), 0);
        chk("mid-press reset mode", int'(bus.modeSelect), 0);
        steps(2'b10, 12);
        #2 chk("held through reset mode", int'(bus.modeSelect), 1);
        steps(2'b11, 10);

        // Long hold: one toggle, pulses depend on the auto-repeat build.
        p0 = pcnt[0];
        m0 = bus.modeSelect;
        steps(2'b10, 36);
        #2;
`ifdef KEY_AUTOREPEAT_EN
        chk("long hold pulses", pcnt[0] - p0, 8);
`else
        chk("long hold pulses", pcnt[0] - p0, 1);
`endif
        chk("long hold mode", int'(bus.modeSelect ^ m0), 1);
        steps(2'b11, 10);

        // Randomized bouncing keys with occasional reset.
        for (int i = 0; i < NK; i++) hold[i] = 0;
        cur = '1;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NK; i++) begin
                if (hold[i] == 0) begin
                    cur[i]  = 1'($urandom_range(0, 1));
                    hold[i] = (($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 40))
                                                           : int'($urandom_range(1, 6)));
                end
                hold[i]--;
            end
            step(cur, ($urandom_range(0, 299) == 0));
        end
        steps(2'b11, 12);
        #2 chk("scoreboard drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
